// File: rtl/uart_rx_cfg.sv
// UART receiver: 5..8 data bits, none/even/odd parity, 1 or 2 stop bits, held word with ack.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at ticks 7/8/9 (default: single sample at tick 7).
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy,
  output logic [2:0]           dbg_state
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [3:0]           tick_cnt;
  logic                 sync1, rxd_s, rxd_q;
  logic                 fall;
  logic                 sample_now, sample_bit;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_acc;
  logic [1:0]           pm_lat;
  logic                 stop2_lat;
  logic                 par_en;
  logic                 stop_cnt;
  logic                 stop_bad;
  logic                 done;
  logic                 done_perr;
  logic                 done_ferr;

  // Free-running 16x baud tick; frames align by clearing tick_cnt, not the divider.
  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
      rxd_q <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
      rxd_q <= rxd_s;
    end
  end

  assign fall = rxd_q & ~rxd_s;

`ifdef UART_RX_MAJORITY_EN
  logic s7, s8;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s7 <= 1'b1;
      s8 <= 1'b1;
    end else if (tick && (tick_cnt == 4'd7)) begin
      s7 <= rxd_s;
    end else if (tick && (tick_cnt == 4'd8)) begin
      s8 <= rxd_s;
    end
  end

  assign sample_now = tick && (tick_cnt == 4'd9);
  assign sample_bit = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);
`else
  assign sample_now = tick && (tick_cnt == 4'd7);
  assign sample_bit = rxd_s;
`endif

  assign par_en = (pm_lat == 2'b01) || (pm_lat == 2'b10);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shift     <= '0;
      par_acc   <= 1'b0;
      pm_lat    <= 2'b00;
      stop2_lat <= 1'b0;
      stop_cnt  <= 1'b0;
      stop_bad  <= 1'b0;
      done      <= 1'b0;
      done_perr <= 1'b0;
      done_ferr <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick) tick_cnt <= tick_cnt + 4'd1;
      case (state)
        S_IDLE: begin
          if (fall) begin
            state     <= S_START;
            tick_cnt  <= 4'd0;
            pm_lat    <= parity_mode;
            stop2_lat <= stop2;
          end
        end
        S_START: begin
          if (sample_now) begin
            if (sample_bit) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
              par_acc <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (sample_now) begin
            shift   <= {sample_bit, shift[DATA_BITS-1:1]};
            par_acc <= par_acc ^ sample_bit;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt  <= 3'd0;
              stop_cnt <= 1'b0;
              stop_bad <= 1'b0;
              state    <= par_en ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (sample_now) begin
            par_acc <= par_acc ^ sample_bit;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (sample_now) begin
            if (stop2_lat && !stop_cnt) begin
              stop_cnt <= 1'b1;
              stop_bad <= ~sample_bit;
            end else begin
              // Even parity flags a set XOR, odd parity flags a clear XOR.
              done      <= 1'b1;
              done_perr <= par_en & (par_acc ^ (pm_lat == 2'b10));
              done_ferr <= stop_bad | ~sample_bit;
              state     <= (stop_bad | ~sample_bit) ? S_BREAK : S_IDLE;
            end
          end
        end
        S_BREAK: begin
          if (rxd_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake: rx_valid holds rx_data and flags until a cycle with rx_ack=1; the word clears on the next
  // edge. rx_ack with rx_valid=0 is ignored. A completion against an unacked word is dropped and flagged.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done) begin
      if (rx_valid && !rx_ack) begin
        overrun_err <= 1'b1;
      end else begin
        rx_data     <= shift;
        parity_err  <= done_perr;
        frame_err   <= done_ferr;
        rx_valid    <= 1'b1;
        overrun_err <= 1'b0;
      end
    end else if (rx_valid && rx_ack) begin
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

  assign rx_busy   = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames, expected words queued at issue time, monitors compare on delivery.
module tb_uart_rx_cfg;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int BIT_CLKS = 160;

  logic       sys_clk;
  logic       rst_n;
  logic       rxd;
  logic       rxd5;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       rx_ack;

  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, rx_busy;
  logic [2:0] dbg_state;

  logic [4:0] rx_data5;
  logic       rx_valid5, parity_err5, frame_err5, overrun_err5, rx_busy5;
  logic [2:0] dbg_state5;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  logic [10:0] exp5_q[$];

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .rxd(rxd), .parity_mode(parity_mode), .stop2(stop2),
    .rx_ack(rx_ack), .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .rx_busy(rx_busy), .dbg_state(dbg_state)
  );

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(5)) dut5 (
    .sys_clk(sys_clk), .rst_n(rst_n), .rxd(rxd5), .parity_mode(parity_mode), .stop2(stop2),
    .rx_ack(rx_ack), .rx_data(rx_data5), .rx_valid(rx_valid5), .parity_err(parity_err5),
    .frame_err(frame_err5), .overrun_err(overrun_err5), .rx_busy(rx_busy5), .dbg_state(dbg_state5)
  );

  // ---------------- clock / reset ----------------
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic clks(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rxd5 = b;
    else     rxd  = b;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input int nb, input logic [1:0] pm,
                            input logic pbit, input logic two, input logic s2bit, input logic [1:0] pm_mid);
    parity_mode = pm;
    stop2       = two;
    drive(sel, 1'b0);
    clks(BIT_CLKS);
    parity_mode = pm_mid;
    for (int i = 0; i < nb; i++) begin
      drive(sel, d[i]);
      clks(BIT_CLKS);
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      drive(sel, pbit);
      clks(BIT_CLKS);
    end
    drive(sel, 1'b1);
    clks(BIT_CLKS);
    if (two) begin
      drive(sel, s2bit);
      clks(BIT_CLKS);
    end
  endtask

  task automatic ack_word();
    rx_ack = 1'b1;
    clks(1);
    rx_ack = 1'b0;
    clks(2);
  endtask

  // Raise rx_ack right after the final stop sample so it is high on the delivery edge.
  task automatic ack_at_done();
    int n;
    n = 0;
    while (dbg_state != 3'd4 && n < 3000) begin clks(1); n++; end
    while (dbg_state == 3'd4 && n < 3000) begin clks(1); n++; end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL ack_timing got %0d cycles exp below 3000", n);
    end else begin
      rx_ack = 1'b1;
      clks(1);
      rx_ack = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  logic mv = 1'b0, ma = 1'b0, mo = 1'b0;
  logic mv5 = 1'b0, ma5 = 1'b0, mo5 = 1'b0;

  always @(negedge sys_clk) begin : mon_main
    logic [10:0] act, expw;
    act = {overrun_err, frame_err, parity_err, rx_data};
    if (rst_n && rx_valid && (!mv || ma || (overrun_err && !mo))) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_main got %0h exp none", act);
      end else begin
        expw = exp_q.pop_front();
        if (act !== expw) begin
          errors++;
          $display("FAIL word_main got %0h exp %0h", act, expw);
        end
      end
    end
    mv = rx_valid;
    ma = rx_ack;
    mo = overrun_err;
  end

  always @(negedge sys_clk) begin : mon_five
    logic [10:0] act, expw;
    act = {overrun_err5, frame_err5, parity_err5, 3'b000, rx_data5};
    if (rst_n && rx_valid5 && (!mv5 || ma5 || (overrun_err5 && !mo5))) begin
      checks++;
      if (exp5_q.size() == 0) begin
        errors++;
        $display("FAIL word_five got %0h exp none", act);
      end else begin
        expw = exp5_q.pop_front();
        if (act !== expw) begin
          errors++;
          $display("FAIL word_five got %0h exp %0h", act, expw);
        end
      end
    end
    mv5 = rx_valid5;
    ma5 = rx_ack;
    mo5 = overrun_err5;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; rxd = 1'b1; rxd5 = 1'b1; rx_ack = 1'b0; parity_mode = 2'b00; stop2 = 1'b0;
    clks(5);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_flags", {parity_err, frame_err, overrun_err}, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst_valid5", rx_valid5, 0);
    rst_n = 1'b1;
    clks(20);

    // 8N1 0xA5 with ack held low
    exp_q.push_back({3'b000, 8'hA5});
    send_frame(0, 8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    clks(20);
    check("a5_busy", rx_busy, 0);
    check("a5_valid", rx_valid, 1);
    ack_word();
    check("a5_ack_clears", rx_valid, 0);

    // Even parity 0x3C: parity bit 1 is wrong, 0 is right
    exp_q.push_back({3'b001, 8'h3C});
    send_frame(0, 8'h3C, 8, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01);
    clks(20); ack_word();
    exp_q.push_back({3'b000, 8'h3C});
    send_frame(0, 8'h3C, 8, 2'b01, 1'b0, 1'b0, 1'b1, 2'b01);
    clks(20); ack_word();
    // Odd parity 0x3C with parity bit 0 is wrong
    exp_q.push_back({3'b001, 8'h3C});
    send_frame(0, 8'h3C, 8, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10);
    clks(20); ack_word();
    // Mode 11 means no parity bit
    exp_q.push_back({3'b000, 8'h3C});
    send_frame(0, 8'h3C, 8, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11);
    clks(20); ack_word();
    // Mode switched to none after the start bit: frame still parsed with even parity
    exp_q.push_back({3'b000, 8'h3C});
    send_frame(0, 8'h3C, 8, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00);
    clks(20); ack_word();

    // Two stop bits, second one low, then line held low
    exp_q.push_back({3'b010, 8'h55});
    send_frame(0, 8'h55, 8, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
    clks(400);
    check("break_state", dbg_state, 5);
    check("break_busy", rx_busy, 1);
    ack_word();
    rxd = 1'b1;
    clks(20);
    check("break_exit", dbg_state, 0);
    check("break_no_word", rx_valid, 0);

    // Back-to-back without ack: overrun keeps 0x11
    exp_q.push_back({3'b000, 8'h11});
    exp_q.push_back({3'b100, 8'h11});
    send_frame(0, 8'h11, 8, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    send_frame(0, 8'h22, 8, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    clks(20);
    check("ovr_data", rx_data, 8'h11);
    ack_word();
    check("ovr_cleared", overrun_err, 0);

    // Ack coinciding with completion loads the new word
    exp_q.push_back({3'b000, 8'h11});
    exp_q.push_back({3'b000, 8'h22});
    send_frame(0, 8'h11, 8, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    fork
      send_frame(0, 8'h22, 8, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
      ack_at_done();
    join
    clks(20);
    check("coin_valid", rx_valid, 1);
    check("coin_ovr", overrun_err, 0);
    ack_word();

    // 60-clock glitch is a false start
    rxd = 1'b0; clks(60); rxd = 1'b1; clks(300);
    check("glitch_state", dbg_state, 0);
    check("glitch_valid", rx_valid, 0);

    // Five data bits
    exp5_q.push_back({3'b000, 8'h1B});
    send_frame(1, 8'h1B, 5, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    clks(20);
    check("five_data", rx_data5, 5'h1B);
    ack_word();

    // Reset mid-frame aborts without delivery
    rxd = 1'b0; clks(BIT_CLKS); rxd = 1'b1; clks(80);
    check("rstmid_busy_before", rx_busy, 1);
    rst_n = 1'b0; clks(5);
    check("rstmid_busy_in", rx_busy, 0);
    rst_n = 1'b1; clks(400);
    check("rstmid_state", dbg_state, 0);
    check("rstmid_valid", rx_valid, 0);

`ifdef UART_RX_MAJORITY_EN
    // One-tick spike in the middle of bit 3 is outvoted
    exp_q.push_back({3'b000, 8'hA5});
    fork
      send_frame(0, 8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
      begin
        clks(BIT_CLKS * 4 + 80);
        rxd = ~rxd;
        clks(10);
        rxd = ~rxd;
      end
    join
    clks(20);
    ack_word();
`endif

    clks(50);
    check("main_queue_empty", exp_q.size(), 0);
    check("five_queue_empty", exp5_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named sys_clk and rst_n.
REQ-002 Parameter CLK_FREQ SHALL default to 100000000 and give the sys_clk frequency in Hz.
REQ-003 Parameter BAUD SHALL default to 115200 and give the line rate in bit/s.
REQ-004 Parameter DATA_BITS SHALL default to 8 and give the data bits per frame; legal range is 5..8.
REQ-005 Port sys_clk SHALL be an input, 1 bit wide: system clock; all logic is clocked on its rising edge.
REQ-006 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-007 Port rxd SHALL be an input, 1 bit wide: asynchronous serial line, idle high.
REQ-008 Port parity_mode SHALL be an input, 2 bits wide: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 Port stop2 SHALL be an input, 1 bit wide: 1 selects two stop bits, 0 selects one.
REQ-010 Port rx_ack SHALL be an input, 1 bit wide: consumer acknowledge of the held word.
REQ-011 Port rx_data SHALL be an output, DATA_BITS wide: received word, LSB-aligned, first line bit in bit 0.
REQ-012 Port rx_valid SHALL be an output, 1 bit wide: rx_data and the error flags hold an unread word.
REQ-013 Ports parity_err, frame_err and overrun_err SHALL be outputs, 1 bit each: error flags for the held word.
REQ-014 Port rx_busy SHALL be an output, 1 bit wide: high in every state other than IDLE.

Function
REQ-015 rxd SHALL pass through a 2-flop synchroniser (reset value 1); all logic SHALL use only the synchronised copy.
REQ-016 A 16x tick SHALL pulse for one sys_clk every DIV = CLK_FREQ/(BAUD*16) cycles (integer truncation, minimum 1); the divider SHALL run freely from reset.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK; any unused encoding SHALL go to IDLE.
REQ-018 IDLE->START SHALL occur on a synchronised 1->0 transition; the 4-bit tick counter SHALL clear at that transition.
REQ-019 In START, at the sample point the line SHALL be checked: low -> DATA; high -> IDLE, with no flags and no rx_valid (false start).
REQ-020 Each subsequent bit SHALL be sampled 16 ticks after the previous sample point; DATA SHALL shift in DATA_BITS bits, LSB first.
REQ-021 PARITY SHALL be entered only when parity_mode is 01 or 10; even parity requires the XOR of data and parity bits to be 0, odd parity requires it to be 1.
REQ-022 STOP SHALL sample one stop bit (stop2=0) or two (stop2=1); frame_err SHALL be set if any sampled stop bit is 0.
REQ-023 parity_mode and stop2 SHALL be latched at IDLE->START; changes mid-frame SHALL have no effect on that frame.
REQ-024 The word SHALL be delivered 1 sys_clk after the final stop-bit sample: rx_data, parity_err and frame_err loaded, rx_valid set; framed-bad words are still delivered.
REQ-025 After a frame_err, the FSM SHALL enter BREAK and return to IDLE only after the synchronised line is seen high; it SHALL NOT accept a start bit while in BREAK.
REQ-026 rx_valid SHALL stay high until a cycle with rx_ack=1, then clear on the next edge; rx_ack while rx_valid=0 SHALL be ignored.
REQ-027 On overrun (a completion while rx_valid=1 and rx_ack=0), the new word SHALL be dropped, rx_data SHALL keep the unread word, and overrun_err SHALL be set until acknowledged.
REQ-028 If completion and rx_ack coincide, the new word SHALL load, rx_valid SHALL stay 1, overrun_err SHALL be 0, and the other flags SHALL come from the new frame.

Reset
REQ-029 While rst_n=0, the following SHALL hold: state IDLE, rx_data all zeros, rx_valid, parity_err, frame_err, overrun_err and rx_busy all 0, synchroniser flops 1, divider and tick counters 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame without delivery; after release, the FSM SHALL wait in IDLE for a new falling edge.

Configuration
REQ-031 With macro UART_RX_MAJORITY_EN defined, each bit SHALL be the 2-of-3 majority of samples at ticks 7, 8 and 9 and be decided at tick 9; the false-start check SHALL also use the majority.
REQ-032 Without UART_RX_MAJORITY_EN, each bit SHALL be the single sample at tick 7; delivery timing (REQ-024) SHALL shift 2 ticks earlier accordingly.

Verification (CLK_FREQ=1600000, BAUD=10000, so DIV=10 and a bit is 160 clocks)
REQ-033 Scenario: 8N1 frame 0xA5, rx_ack held 0 -> rx_data=0xA5, rx_valid=1, all flags 0, rx_busy=0.
REQ-034 Scenario: parity_mode=01 frame 0x3C with parity bit 1 -> rx_data=0x3C, parity_err=1; repeated with parity bit 0 -> parity_err=0.
REQ-035 Scenario: stop2=1 frame 0x55 with second stop bit 0, line then held low for 400 clocks -> frame_err=1, FSM stays in BREAK until rxd goes high, and no second word is delivered.
REQ-036 Scenario: two back-to-back frames 0x11 then 0x22 with no ack -> rx_data=0x11, overrun_err=1; ack on the exact cycle the second frame completes -> rx_data=0x22, overrun_err=0.
REQ-037 Scenario: 60-clock low glitch on idle rxd -> no rx_valid; DATA_BITS=5 frame 0x1B -> rx_data=5'h1B; reset pulse mid-frame -> no delivery.
REQ-038 Scenario (UART_RX_MAJORITY_EN defined): one-tick spike at tick 8 of bit 3 -> word unaffected.
